// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode/funct codes, ALU op codes, PC select codes and FSM state encodings
// for the multi-cycle MIPS-subset controller.
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational Opcode/Funct -> ALU operation, shamt select and legality.
// j and the halt opcode are reported illegal here; the controller handles them itself.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic       legal
);
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OP_R: begin
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SLL: begin
                        alu_op    = ALU_SLL;
                        alu_src_a = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
            OP_ORI:  alu_op = ALU_OR;
            OP_BEQ:  alu_op = ALU_SUB;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF->ID->EXE->MEM->WB sequencer driving all datapath enables and selects.
// Define CTRL_HALT_EN to make opcode 111111 park the FSM in sHALT until reset.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic [STATE_W-1:0] State,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               IRWre,
    output logic               ExtSel,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               RegDst,
    output logic               RegWre,
    output logic               MemWre,
    output logic               DBDataSrc
);
`ifdef CTRL_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [2:0] alu_op;
    logic       alu_src_a, legal;

    alu_op_decode u_dec (
        .opcode   (Opcode),
        .funct    (Funct),
        .alu_op   (alu_op),
        .alu_src_a(alu_src_a),
        .legal    (legal)
    );

    wire is_r    = Opcode == OP_R;
    wire is_j    = Opcode == OP_J;
    wire is_beq  = Opcode == OP_BEQ;
    wire is_addi = Opcode == OP_ADDI;
    wire is_ori  = Opcode == OP_ORI;
    wire is_lw   = Opcode == OP_LW;
    wire is_sw   = Opcode == OP_SW;
    wire is_halt = HALT_EN && Opcode == OP_HALT;

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = is_halt ? S_HALT : (legal ? S_EXE : S_IF);
            S_EXE:   state_d = is_beq ? S_IF : ((is_lw || is_sw) ? S_MEM : S_WB);
            S_MEM:   state_d = is_sw ? S_IF : S_WB;
            S_HALT:  state_d = HALT_EN ? S_HALT : S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IF;
        else      state_q <= state_d;
    end

    // Every output is gated by RST so nothing reaches the datapath while reset is held.
    wire run = RST;
    assign State     = run ? STATE_W'(state_q) : '0;
    assign IRWre     = run && state_q == S_IF;
    assign PCWre     = run && (state_q == S_IF || (state_q == S_ID && is_j) ||
                               (state_q == S_EXE && is_beq && Zero));
    assign PCSrc     = !run ? PC_SEQ :
                       (state_q == S_ID && is_j) ? PC_JMP :
                       (state_q == S_EXE && is_beq) ? PC_BR : PC_SEQ;
    assign MemWre    = run && state_q == S_MEM && is_sw;
    assign RegWre    = run && state_q == S_WB;
    assign ExtSel    = run && (is_addi || is_lw || is_sw || is_beq);
    assign ALUSrcA   = run && alu_src_a;
    assign ALUSrcB   = run && (is_addi || is_ori || is_lw || is_sw);
    assign ALUOp     = run ? alu_op : ALU_ADD;
    assign RegDst    = run && is_r && legal;
    assign DBDataSrc = run && is_lw;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream checked against a per-instruction-class model
// that derives state paths, enables and selects from the instruction's class.
module tb_multicycle_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] Opcode = 6'b100011, Funct = 6'b0;
    logic       Zero = 1'b0;
    logic [2:0] State;
    logic       PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, RegDst, RegWre, MemWre, DBDataSrc;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl #(.STATE_W(3)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .State(State), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .RegWre(RegWre), .MemWre(MemWre), .DBDataSrc(DBDataSrc)
    );

    always #5 CLK = ~CLK;

    // Instruction classes: 0 nop/illegal, 1 j, 2 beq, 3 sw, 4 reg-writing ALU op, 5 lw, 6 halt
    typedef struct {
        int         kind;
        logic       ext, sa, sb, rd, db;
        logic [2:0] aop;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t op=%b fn=%b)", tag, got, exp, $time, Opcode, Funct);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        e = '{kind: 0, ext: 0, sa: 0, sb: 0, rd: 0, db: 0, aop: 3'd0};
        case (op)
            6'b000000: begin
                e.kind = 4;
                e.rd   = 1;
                case (fn)
                    6'b100000: e.aop = 3'd0;
                    6'b100010: e.aop = 3'd1;
                    6'b100100: e.aop = 3'd2;
                    6'b100101: e.aop = 3'd3;
                    6'b101010: e.aop = 3'd4;
                    6'b000000: begin e.aop = 3'd5; e.sa = 1; end
                    default:   e.kind = 0;
                endcase
            end
            6'b000010: e.kind = 1;
            6'b000100: begin e.kind = 2; e.ext = 1; e.aop = 3'd1; end
            6'b001000: begin e.kind = 4; e.ext = 1; e.sb = 1; end
            6'b001101: begin e.kind = 4; e.sb = 1; e.aop = 3'd3; end
            6'b100011: begin e.kind = 5; e.ext = 1; e.sb = 1; e.db = 1; end
            6'b101011: begin e.kind = 3; e.ext = 1; e.sb = 1; end
`ifdef CTRL_HALT_EN
            6'b111111: e.kind = 6;
`endif
            default: e.kind = 0;
        endcase
        return e;
    endfunction

    // State paths: j and nop 2 cycles, beq/sw 3-4 visible states, ALU 4, lw 5.
    function automatic int path_len(input int kind);
        case (kind)
            2: return 3;
            3, 4: return 4;
            5: return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int path_state(input int kind, input int k);
        if (k < 3) return k;
        if (k == 3) return (kind == 3 || kind == 5) ? 3 : 4;
        return 4;
    endfunction

    // Expects to be entered while the DUT sits in sIF, between a negedge and the next posedge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zf);
        exp_t e;
        int   s;
        logic z;
        e = model(op, fn);
        Opcode = op;
        Funct = fn;
        for (int k = 0; k < path_len(e.kind); k++) begin
            s = path_state(e.kind, k);
            z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
            Zero = z;
            #1;
            chk("state", {29'd0, State}, 32'(s));
            chk("irwre", {31'd0, IRWre}, {31'd0, s == 0});
            chk("pcwre", {31'd0, PCWre},
                {31'd0, s == 0 || (s == 1 && e.kind == 1) || (s == 2 && e.kind == 2 && z)});
            chk("memwre", {31'd0, MemWre}, {31'd0, s == 3 && e.kind == 3});
            chk("regwre", {31'd0, RegWre}, {31'd0, s == 4});
            if (s == 0) chk("pcsrc_if", {30'd0, PCSrc}, 32'd0);
            if (s == 1 && e.kind == 1) chk("pcsrc_j", {30'd0, PCSrc}, 32'd2);
            if (s == 2 && e.kind == 2) chk("pcsrc_beq", {30'd0, PCSrc}, 32'd1);
            if (s != 0 && e.kind >= 2 && e.kind <= 5)
                chk("selects", {24'd0, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst, DBDataSrc},
                    {24'd0, e.ext, e.sa, e.sb, e.aop, e.rd, e.db});
            if (s != 0 && e.kind == 1) chk("extsel_j", {31'd0, ExtSel}, 32'd0);
            @(negedge CLK);
        end
        if (e.kind == 6) begin
            repeat (10) begin
                #1;
                chk("halt_state", {29'd0, State}, 32'd5);
                chk("halt_en", {28'd0, IRWre, PCWre, MemWre, RegWre}, 32'd0);
                @(negedge CLK);
            end
            RST = 1'b0;
            #1;
            chk("halt_rst", {29'd0, State}, 32'd0);
            @(negedge CLK);
            RST = 1'b1;
        end
    endtask

    function automatic logic [16:0] all_out();
        return {State, PCWre, PCSrc, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWre,
                MemWre, DBDataSrc};
    endfunction

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001101, 6'b100011};
    logic [5:0] legal_fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    initial begin
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("reset_outputs", {15'd0, all_out()}, 32'd0);
        end
        RST = 1'b1;
        run_instr(6'b001000, 6'b000000, -1);
        run_instr(6'b001101, 6'b000000, -1);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b100011, 6'b000000, 1);
        run_instr(6'b101011, 6'b000000, 1);
        run_instr(6'b000010, 6'b000000, 1);
        run_instr(6'b010111, 6'b000000, 1);
        run_instr(6'b000000, 6'b000000, -1);
        run_instr(6'b000000, 6'b111111, -1);
        run_instr(6'b111111, 6'b000000, -1);

        // Abort a store while it sits in sMEM: the write must never reach the datapath.
        Opcode = 6'b101011;
        repeat (3) @(negedge CLK);
        #1;
        chk("sw_in_mem", {29'd0, State}, 32'd3);
        RST = 1'b0;
        #1;
        chk("sw_abort_outputs", {15'd0, all_out()}, 32'd0);
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk("sw_abort_memwre", {31'd0, MemWre}, 32'd0);
        end
        RST = 1'b1;
        run_instr(6'b101011, 6'b000000, -1);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op, fn;
            case ($urandom_range(0, 9))
                0, 1:    op = 6'b000000;
                2:       op = 6'b101011;
                3:       op = 6'b111111;
                4, 5:    op = $urandom_range(0, 63);
                default: op = legal_ops[$urandom_range(0, 5)];
            endcase
            fn = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : legal_fns[$urandom_range(0, 5)];
            run_instr(op, fn, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
